// File: rtl/result_collector.sv
// Re-aligns skewed systolic-array result lanes into whole rows, buffers them in a
// show-ahead FIFO and tracks rows per tile. RESULT_RELU_EN clamps negative lanes to 0 at FIFO write.
module result_collector #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_W-1:0]               num_rows,
    input  logic [SYS_COLS-1:0]            col_valid,
    input  logic [SYS_COLS*P_BITWIDTH-1:0] col_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SYS_COLS*P_BITWIDTH-1:0] out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic                           skew_err
);
    localparam int ROW_W      = SYS_COLS * P_BITWIDTH;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W     = PTR_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [SYS_COLS-1:0] dly_valid;
    logic [ROW_W-1:0]    dly_data;
    logic [ROW_W-1:0]    wr_row;

    // Lane gi is delayed SYS_COLS-1-gi cycles so every lane of a row lands together.
    genvar gi;
    generate
        for (gi = 0; gi < SYS_COLS; gi++) begin : g_lane
            localparam int DLY = SYS_COLS - 1 - gi;
            if (DLY == 0) begin : g_pass
                assign dly_valid[gi] = col_valid[gi];
                assign dly_data[gi*P_BITWIDTH +: P_BITWIDTH] = col_data[gi*P_BITWIDTH +: P_BITWIDTH];
            end else begin : g_dly
                logic [DLY-1:0]        v_pipe_reg;
                logic [P_BITWIDTH-1:0] d_pipe_reg [DLY];
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        v_pipe_reg <= '0;
                        for (int k = 0; k < DLY; k++) begin
                            d_pipe_reg[k] <= '0;
                        end
                    end else begin
                        v_pipe_reg[0] <= col_valid[gi];
                        d_pipe_reg[0] <= col_data[gi*P_BITWIDTH +: P_BITWIDTH];
                        for (int k = 1; k < DLY; k++) begin
                            v_pipe_reg[k] <= v_pipe_reg[k-1];
                            d_pipe_reg[k] <= d_pipe_reg[k-1];
                        end
                    end
                end
                assign dly_valid[gi] = v_pipe_reg[DLY-1];
                assign dly_data[gi*P_BITWIDTH +: P_BITWIDTH] = d_pipe_reg[DLY-1];
            end
        end

        for (gi = 0; gi < SYS_COLS; gi++) begin : g_wr_lane
`ifdef RESULT_RELU_EN
            assign wr_row[gi*P_BITWIDTH +: P_BITWIDTH] =
                dly_data[gi*P_BITWIDTH + P_BITWIDTH - 1] ? '0 : dly_data[gi*P_BITWIDTH +: P_BITWIDTH];
`else
            assign wr_row[gi*P_BITWIDTH +: P_BITWIDTH] = dly_data[gi*P_BITWIDTH +: P_BITWIDTH];
`endif
        end
    endgenerate

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  num_rows_q;
    logic [CNT_W-1:0]  rows_in_reg;
    logic [CNT_W-1:0]  rows_out_reg;
    logic [CNT_W-1:0]  dropped_reg;
    logic              overflow_reg;
    logic              skew_err_reg;
    logic              done_reg;

    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FCNT_W-1:0] count_reg;
    logic [ROW_W-1:0]  mem [FIFO_DEPTH];
    logic              last_mem [FIFO_DEPTH];
    logic [ROW_W-1:0]  last_data_reg;

    logic any_v, all_v, start_ok, row_accept, push, drop, pop;
    logic fifo_empty, fifo_full, row_last, drained;

    assign any_v      = |dly_valid;
    assign all_v      = &dly_valid;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FCNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && out_ready;
    assign start_ok   = start && (state_reg == ST_IDLE);
    assign row_accept = (state_reg == ST_COLLECT) && all_v && (rows_in_reg < num_rows_q);
    // A full FIFO can still take the row when the head leaves on the same edge.
    assign push       = row_accept && (!fifo_full || pop);
    assign drop       = row_accept && !push;
    assign row_last   = (rows_in_reg == num_rows_q - CNT_W'(1));
    assign drained    = (({1'b0, rows_out_reg} + {1'b0, dropped_reg}) == {1'b0, num_rows_q});

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rows_in_reg == num_rows_q) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && drained) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            num_rows_q   <= '0;
            rows_in_reg  <= '0;
            rows_out_reg <= '0;
            dropped_reg  <= '0;
            overflow_reg <= 1'b0;
            skew_err_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_DONE);
            if (start_ok) begin
                num_rows_q   <= num_rows;
                rows_in_reg  <= '0;
                rows_out_reg <= '0;
                dropped_reg  <= '0;
                overflow_reg <= 1'b0;
                skew_err_reg <= 1'b0;
            end else begin
                if (row_accept) begin
                    rows_in_reg <= rows_in_reg + CNT_W'(1);
                end
                if (pop) begin
                    rows_out_reg <= rows_out_reg + CNT_W'(1);
                end
                if (drop) begin
                    dropped_reg  <= dropped_reg + CNT_W'(1);
                    overflow_reg <= 1'b1;
                end
                if (any_v && !all_v) begin
                    skew_err_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            last_data_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
                last_data_reg <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + FCNT_W'(1);
                2'b01:   count_reg <= count_reg - FCNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset so it maps onto RAM; validity comes from count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg]      <= wr_row;
            last_mem[wr_ptr_reg] <= row_last;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? last_data_reg : mem[rd_ptr_reg];
    assign out_last  = !fifo_empty && last_mem[rd_ptr_reg];
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign overflow  = overflow_reg;
    assign skew_err  = skew_err_reg;

endmodule

// File: tb/tb_result_collector.sv
// Randomized self-checking bench for result_collector: expected rows come from a
// row-level model (schedule of rows, FIFO capacity, optional RESULT_RELU_EN clamp).
`timescale 1ns/1ps
module tb_result_collector;
    localparam int NC    = 4;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int ROW_W = NC * W;
    localparam int SCH   = 256;
    localparam int LIMIT = 220;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CW-1:0]    num_rows;
    logic [NC-1:0]    col_valid;
    logic [ROW_W-1:0] col_data;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             overflow;
    logic             skew_err;

    always #5 clk = ~clk;

    result_collector #(
        .SYS_COLS(NC), .P_BITWIDTH(W), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .col_valid(col_valid), .col_data(col_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done),
        .overflow(overflow), .skew_err(skew_err)
    );

    int checks = 0;
    int errors = 0;

    logic [NC-1:0]    sch_v [SCH];
    logic [ROW_W-1:0] sch_d [SCH];
    logic [ROW_W-1:0] rows_tbl [16];
    logic [ROW_W-1:0] exp_q [$];
    logic             exp_last_q [$];

    task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] model_row(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        o = r;
`ifdef RESULT_RELU_EN
        for (int j = 0; j < NC; j++) begin
            if ($signed(r[j*W +: W]) < 0) o[j*W +: W] = '0;
        end
`endif
        return o;
    endfunction

    task automatic set_lane(input int r, input int j, input int val);
        rows_tbl[r][j*W +: W] = W'(val);
    endtask

    task automatic clear_sched();
        for (int c = 0; c < SCH; c++) begin
            sch_v[c] = '0;
            sch_d[c] = '0;
        end
    endtask

    // Lane j of a row starting at cycle s is presented at s+j; 'late' delays lane 2 by one.
    task automatic add_row(input int s, input logic [ROW_W-1:0] row, input bit late);
        for (int j = 0; j < NC; j++) begin
            int t;
            t = s + j + ((late && j == 2) ? 1 : 0);
            sch_v[t][j] = 1'b1;
            sch_d[t][j*W +: W] = row[j*W +: W];
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 held low until hold_after cycles past the last alignment
    task automatic run_tile(input string name, input int n, input int ready_mode, input int hold_after,
                            input int skew_row, input int keep, input int busy_start_cyc, input int gap_max);
        int s, k, n_sched, first_align, last_align, release_cyc;
        int done_cyc, done_cnt, first_valid;
        bit popped;
        logic [ROW_W-1:0] last_exp;

        clear_sched();
        exp_q.delete();
        exp_last_q.delete();
        n_sched = n + ((skew_row >= 0) ? 1 : 0);
        s = 2; k = 0; first_align = -1; last_align = -1;
        for (int r = 0; r < n_sched; r++) begin
            add_row(s, rows_tbl[r], r == skew_row);
            if (r != skew_row) begin
                if (first_align < 0) first_align = s + NC - 1;
                last_align = s + NC - 1;
                if (k < keep) begin
                    exp_q.push_back(model_row(rows_tbl[r]));
                    exp_last_q.push_back(k == n - 1);
                end
                k++;
            end
            s = s + 1 + ((r == skew_row) ? 1 : 0) + ((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        release_cyc = (ready_mode == 2) ? last_align + hold_after : 0;

        @(negedge clk);
        start = 1'b1; num_rows = CW'(n); col_valid = '0; col_data = '0;
        out_ready = (ready_mode == 0);
        done_cyc = -1; done_cnt = 0; first_valid = -1; popped = 0; last_exp = '0;

        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge clk);
            start     = (cyc == busy_start_cyc);
            num_rows  = (cyc == busy_start_cyc) ? CW'(1) : CW'(n);
            col_valid = sch_v[cyc];
            col_data  = sch_d[cyc];
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = (cyc >= release_cyc);
            endcase
            #1;
            if (cyc == 0) begin
                check({name, ":ovf_clr"}, overflow, 1'b0);
                check({name, ":skew_clr"}, skew_err, 1'b0);
                check({name, ":busy"}, busy, 1'b1);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    check({name, ":spurious_valid"}, out_valid, 1'b0);
                end else begin
                    check({name, ":head_data"}, out_data, exp_q[0]);
                    check({name, ":head_last"}, out_last, exp_last_q[0]);
                    if (out_ready) begin
                        $display("%s pop data=%h last=%0b", name, out_data, out_last);
                        last_exp = exp_q.pop_front();
                        void'(exp_last_q.pop_front());
                        popped = 1;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;

        check({name, ":done_cnt"}, done_cnt, 1);
        check({name, ":rows_left"}, exp_q.size(), 0);
        check({name, ":overflow"}, overflow, keep < n);
        check({name, ":skew_err"}, skew_err, skew_row >= 0);
        check({name, ":busy_end"}, busy, 1'b0);
        if (n == 0) check({name, ":done_lat"}, done_cyc, 1);
        else if (keep > 0) check({name, ":valid_lat"}, first_valid, first_align + 1);
        if (popped) check({name, ":hold_data"}, out_data, last_exp);
        $display("%s tile n=%0d done_cyc=%0d first_valid=%0d", name, n, done_cyc, first_valid);
    endtask

    initial begin
        int dcnt;
        rst = 1'b0; start = 1'b0; num_rows = '0; col_valid = '0; col_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset:out_valid", out_valid, 1'b0);
        check("reset:out_data", out_data, '0);
        check("reset:busy", busy, 1'b0);
        check("reset:flags", {done, overflow, skew_err, out_last}, 4'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int r = 0; r < 3; r++) for (int j = 0; j < NC; j++) set_lane(r, j, 10 * r + j);
        run_tile("basic", 3, 0, 0, -1, 3, -1, 0);

        for (int r = 0; r < 6; r++) for (int j = 0; j < NC; j++) set_lane(r, j, 100 + 10 * r + j);
        run_tile("backpressure", 6, 2, 10, -1, 6, -1, 0);

        for (int r = 0; r < 10; r++) for (int j = 0; j < NC; j++) set_lane(r, j, 200 + 10 * r + j);
        run_tile("overflow", 10, 2, 5, -1, DEPTH, -1, 0);

        for (int r = 0; r < 3; r++) for (int j = 0; j < NC; j++) set_lane(r, j, 300 + 10 * r + j);
        run_tile("skew", 2, 0, 0, 0, 2, -1, 0);

        for (int r = 0; r < 4; r++) for (int j = 0; j < NC; j++) set_lane(r, j, 400 + 10 * r + j);
        run_tile("busy_start", 4, 0, 0, -1, 4, 3, 0);

        run_tile("zero_rows", 0, 0, 0, -1, 0, -1, 0);

        set_lane(0, 0, -5); set_lane(0, 1, 7); set_lane(0, 2, -1); set_lane(0, 3, 0);
        run_tile("relu", 1, 0, 0, -1, 1, -1, 0);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(1, DEPTH));
            for (int r = 0; r < n; r++) for (int j = 0; j < NC; j++) set_lane(r, j, int'($urandom));
            run_tile("random", n, 1, 0, -1, n, -1, 2);
        end

        // Abort a tile mid-COLLECT with a row buffered and skew_err already raised.
        clear_sched();
        for (int j = 0; j < NC; j++) begin
            set_lane(0, j, 500 + j);
            set_lane(1, j, 510 + j);
        end
        add_row(2, rows_tbl[0], 1'b1);
        add_row(5, rows_tbl[1], 1'b0);
        @(negedge clk);
        start = 1'b1; num_rows = CW'(5); out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            start = 1'b0; col_valid = sch_v[c]; col_data = sch_d[c];
        end
        #1;
        check("rstmid:pre_valid", out_valid, 1'b1);
        check("rstmid:pre_skew", skew_err, 1'b1);
        check("rstmid:pre_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("rstmid:out_valid", out_valid, 1'b0);
        check("rstmid:out_data", out_data, '0);
        check("rstmid:busy", busy, 1'b0);
        check("rstmid:flags", {done, overflow, skew_err, out_last}, 4'b0);
        col_valid = '0; col_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (done) dcnt++;
        end
        check("rstmid:no_done", dcnt, 0);
        check("rstmid:idle_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Receives the skewed per-column partial-sum outputs of the systolic array and re-aligns them into whole rows.
- Buffers the aligned rows in a small FIFO and streams them to the output-memory writer over a valid/ready handshake.
- Sits between the systolic array result bus and the output buffer/writer inside the accelerator datapath.
- Counts rows per layer tile and signals completion to the controller.

Parameters:
- SYS_COLS, 4, number of systolic array columns (result lanes)
- P_BITWIDTH, 32, bit width of each partial-sum lane (two's complement)
- FIFO_DEPTH, 8, aligned-row FIFO depth; power of two, ≥2
- CNT_W, 8, width of the row counter and num_rows

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: begin a tile; latches num_rows
- num_rows  in  CNT_W  rows expected in this tile
- col_valid  in  SYS_COLS  per-lane valid; lane j for row r arrives exactly j cycles after lane 0
- col_data  in  SYS_COLS*P_BITWIDTH  packed lane data, lane j at bits [j*P_BITWIDTH +: P_BITWIDTH]
- out_valid  out  1  aligned row available at FIFO head
- out_ready  in  1  downstream accepts head row
- out_data  out  SYS_COLS*P_BITWIDTH  aligned row, same lane packing
- out_last  out  1  head row is row num_rows-1
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at tile completion
- overflow  out  1  sticky: an aligned row was dropped because the FIFO was full
- skew_err  out  1  sticky: lane valids disagreed at alignment

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; FIFO is emptied; counters and delay lines are cleared.
  - All outputs are 0.
  - Reset asserted mid-tile aborts the tile with no done pulse.
- Deskew:
  - Lane j (data and valid) passes through SYS_COLS-1-j registers. Lane SYS_COLS-1 has zero delay.
  - Delay lines run in every state.
- Alignment:
  - Each cycle, aligned_valid = AND of all delayed lane valids.
  - If some, but not all, delayed valids are set, skew_err is set (sticky) and no row is written.
- FIFO write:
  - Occurs only in COLLECT, when aligned_valid is high and rows_in < num_rows_q.
  - rows_in increments on every such alignment, even when the row is dropped.
- FIFO full:
  - If out_valid && out_ready in the same cycle, push and pop both occur.
  - Otherwise the row is dropped and overflow is set (sticky).
- Latency: lane 0 sampled at cycle T gives lane SYS_COLS-1 at T+SYS_COLS-1, FIFO write at that edge, and out_valid at T+SYS_COLS.
- Output:
  - FIFO is show-ahead; out_data is stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready. Empty gives out_valid=0 and out_data holds the last value.
- out_last: high when the head row's index equals num_rows_q-1. Each FIFO entry stores a last bit.
- State machine:
  - IDLE: on start, latch num_rows, clear rows_in, rows_out, overflow and skew_err.
    - If num_rows==0, go to DONE; otherwise go to COLLECT.
  - COLLECT: when rows_in reaches num_rows_q, go to DRAIN. Further aligned rows are ignored without error.
  - DRAIN: when the FIFO is empty and rows_out (pops) plus dropped rows equals num_rows_q, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE: ignored.
- Sticky flags: hold until the next accepted start or reset.

Optional Feature:
- Macro: RESULT_RELU_EN
- Defined: each lane is treated as signed at FIFO write. Negative values are written as 0; non-negative values pass unchanged.
- Undefined: lanes are written unmodified.
- Flag and handshake behaviour are identical in both builds.

Test Plan:
- Basic tile: SYS_COLS=4, num_rows=3, rows r=0..2 with lane j value 10*r+j skewed correctly, out_ready=1.
  - out_valid rises 4 cycles after first lane-0 valid; rows {0,1,2,3},{10,11,12,13},{20,21,22,23}.
  - out_last only on the third row; done pulses once; overflow=skew_err=0.
- Backpressure: FIFO_DEPTH=8, num_rows=6, out_ready=0 until 10 cycles after the last alignment.
  - All 6 rows are held, then drained in order; out_data stable while stalled; no overflow.
- Overflow: FIFO_DEPTH=8, num_rows=10, out_ready=0 throughout, then 1.
  - Rows 8 and 9 are dropped and overflow=1; 8 rows drain; done still pulses.
- Skew error: lane 2 valid one cycle late for row 0.
  - skew_err=1; row 0 is not written.
  - A subsequent start clears skew_err.
- Edge cases:
  - num_rows=0: done pulses 2 cycles after start with no output.
  - start while busy: ignored; num_rows_q unchanged.
  - rst low mid-COLLECT: all outputs 0 immediately, no done.
- RELU build: lane values {-5,7,-1,0}; out_data is {0,7,0,0} with macro defined and {-5,7,-1,0} without.
